// File: rtl/arbiter_rr_param.sv
// Registered N-way arbiter: round-robin or fixed priority, with a hold limit.
// Ports: clk, reset (sync, active-high), r[N], prio_mode -> g[N], gid, busy.
module arbiter_rr_param #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         r,
    input  logic                 prio_mode,
    output logic [N-1:0]         g,
    output logic [$clog2(N)-1:0] gid,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   g_q, g_d;
    logic [IW-1:0]  gid_q, gid_d;
    logic           busy_q, busy_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [IW-1:0]  last_q, last_d;

    logic [N-1:0]   cand;
    logic [N-1:0]   others;
    logic           take;
    logic [IW-1:0]  pick;

    // First set bit at or after last+1, wrapping.
    function automatic logic [IW-1:0] pick_rr(
        input logic [N-1:0]  req,
        input logic [IW-1:0] last
    );
        logic [IW-1:0] w;
        logic [IW-1:0] jj;
        logic          found;
        int            j;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = int'(last) + k;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                w     = jj;
            end
        end
        return w;
    endfunction

    // Lowest set bit wins.
    function automatic logic [IW-1:0] pick_fix(input logic [N-1:0] req);
        logic [IW-1:0] w;
        w = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[IW'(k)]) w = IW'(k);
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        gid_d   = gid_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        last_d  = last_q;
        cand    = '0;
        take    = 1'b0;
        // g_q is zero in IDLE, so this is r minus the current grantee.
        others  = r & ~g_q;

        unique case (state_q)
            IDLE: begin
                cand = r;
                take = |r;
            end
            GRANT: begin
                if (r[gid_q]) begin
                    if (|others && hold_q == HMAX) begin
                        // Hold expired with contention: rotate away.
                        cand = others;
                        take = 1'b1;
                    end else if (hold_q != HMAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    // Release hands over in the same edge when possible.
                    cand = others;
                    take = |others;
                    if (!take) begin
                        state_d = IDLE;
                        g_d     = '0;
                        gid_d   = '0;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end
            end
            default: ;
        endcase

        pick = prio_mode ? pick_fix(cand) : pick_rr(cand, last_q);

        if (take) begin
            state_d   = GRANT;
            g_d       = '0;
            g_d[pick] = 1'b1;
            gid_d     = pick;
            busy_d    = 1'b1;
            last_d    = pick;
            hold_d    = '0;
        end
    end

    assign g    = g_q;
    assign gid  = gid_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Randomized and directed checks of arbiter_rr_param (N=4, MAX_HOLD=4)
// against a behavioural model of the arbitration rules.
module tb_arbiter_rr_param;

    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] r;
    logic         prio_mode;
    logic [N-1:0] g;
    logic [1:0]   gid;
    logic         busy;

    int n_err = 0;
    int n_chk = 0;

    // Model: current grantee (-1 = none), cycles held, last grantee.
    int m_cur;
    int m_hold;
    int m_last;

    arbiter_rr_param #(.N(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .r         (r),
        .prio_mode (prio_mode),
        .g         (g),
        .gid       (gid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int choose(input int req, input bit pm, input int last);
        if (pm) begin
            for (int i = 0; i < N; i++)
                if (req[i]) return i;
        end else begin
            for (int s = 1; s <= N; s++)
                if (req[(last + s) % N]) return (last + s) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst, input int rv, input bit pm);
        int others;
        int w;
        if (rst) begin
            m_cur  = -1;
            m_hold = 0;
            m_last = N - 1;
            return;
        end
        others = (m_cur >= 0) ? (rv & ~(1 << m_cur)) : rv;
        if (m_cur >= 0 && rv[m_cur]) begin
            if (others != 0 && m_hold == MH - 1) begin
                w = choose(others, pm, m_last);
                m_cur = w; m_last = w; m_hold = 0;
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end else if (others != 0) begin
            w = choose(others, pm, m_last);
            m_cur = w; m_last = w; m_hold = 0;
        end else begin
            m_cur = -1; m_hold = 0;
        end
    endtask

    task automatic step(input bit rst, input logic [N-1:0] rv, input bit pm);
        int eg;
        reset     = rst;
        r         = rv;
        prio_mode = pm;
        @(posedge clk);
        model_step(rst, int'(rv), pm);
        #1;
        eg = (m_cur < 0) ? 0 : (1 << m_cur);
        check("g", g, eg);
        check("gid", gid, (m_cur < 0) ? 0 : m_cur);
        check("busy", busy, m_cur >= 0);
        check("onehot", $onehot0(g), 1);
        check("gid_vs_g", (g == 0) ? (gid == 0) : (g == (4'b1 << gid)), 1);
    endtask

    initial begin
        logic [N-1:0] seq [5];
        logic [N-1:0] rv;
        bit           pm;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;
        m_cur = -1; m_hold = 0; m_last = N - 1;
        reset = 1'b1; r = 4'b1111; prio_mode = 1'b0;

        // Reset with all requests held, then release.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1111, 1'b0);
            check("rst_g", g, 0);
        end
        step(1'b0, 4'b1111, 1'b0);
        check("first_g", g, 4'b0001);
        check("first_gid", gid, 0);

        // Each grantee drops its request right after being granted.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        check("rr_seq0", g, seq[0]);
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 4'b1111 & ~g, 1'b0);
            check("rr_seq", g, seq[i]);
        end

        // Two steady requesters alternate every MAX_HOLD cycles.
        step(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 4'b0011, 1'b0);
            check("hold_alt", g, ((c / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
        end

        // Lone requester is never rotated away, then releases to idle.
        step(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 4'b0100, 1'b0);
            check("lone", g, 4'b0100);
        end
        step(1'b0, 4'b0000, 1'b0);
        check("release_g", g, 0);
        check("release_busy", busy, 0);

        // Fixed priority: bit 2 held to expiry, then bit 0 is not preempted.
        step(1'b0, 4'b0100, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b0101, 1'b1);
            check("fix_hold", g, 4'b0100);
        end
        step(1'b0, 4'b0101, 1'b1);
        check("fix_rot", g, 4'b0001);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b0111, 1'b1);
            check("no_preempt", g, 4'b0001);
        end

        // Random traffic with mode changes and occasional mid-grant reset.
        pm = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rv = 4'($urandom);
            if ($urandom_range(0, 3) != 0 && g != 0) rv = rv | g;
            if ($urandom_range(0, 29) == 0) pm = ~pm;
            step($urandom_range(0, 49) == 0, rv, pm);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
